// File: rtl/branch_pkg.sv
// Shared types for branch resolution: condition codes, flag bit positions
// and the decoded branch kind.
package branch_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [2:0] {
    KIND_NONE  = 3'd0,
    KIND_B     = 3'd1,
    KIND_CBZ   = 3'd2,
    KIND_CBNZ  = 3'd3,
    KIND_BCOND = 3'd4
  } br_kind_e;

  // The offset is a word count; the shift and add wrap modulo 2^64.
  function automatic logic [63:0] branch_target(input logic [63:0] pc,
                                                input logic [63:0] imm);
    return pc + {imm[61:0], 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Combinational evaluation of a B.cond condition code against N/Z/V/C.
module cond_eval
  import branch_pkg::*;
(
  input  cond_e      cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic n, z, v, c;
  logic hi, ge, gt;

  assign n  = flags_i[FLAG_N];
  assign z  = flags_i[FLAG_Z];
  assign v  = flags_i[FLAG_V];
  assign c  = flags_i[FLAG_C];
  assign hi = c & ~z;
  assign ge = (n == v);
  assign gt = ~z & ge;

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      EQ: taken_o = z;
      NE: taken_o = ~z;
      HS: taken_o = c;
      LO: taken_o = ~c;
      MI: taken_o = n;
      PL: taken_o = ~n;
      VS: taken_o = v;
      VC: taken_o = ~v;
      HI: taken_o = hi;
      LS: taken_o = ~hi;
      GE: taken_o = ge;
      LT: taken_o = ~ge;
      GT: taken_o = gt;
      LE: taken_o = ~gt;
      AL: taken_o = 1'b1;
      NV: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves B/CBZ/CBNZ/B.cond one cycle after decode, drives the front-end
// flush and keeps resolved/taken statistics.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       flag_q,
  input  logic             ex_set_flags,
  input  logic [3:0]       ex_flags,
  input  logic             id_valid,
  input  logic             id_is_b,
  input  logic             id_is_cbz,
  input  logic             id_is_cbnz,
  input  logic             id_is_bcond,
  input  logic [3:0]       id_cond,
  input  logic             id_rt_zero,
  input  logic [63:0]      id_pc,
  input  logic [63:0]      id_imm,
  output logic             br_valid,
  output logic             br_taken,
  output logic [63:0]      br_target,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  logic [3:0]       eff_flags;
  logic             bcond_taken;
  br_kind_e         kind;
  logic             accept;
  logic             taken_now;

  logic             br_valid_q, br_valid_d;
  logic             br_taken_q, br_taken_d;
  logic [63:0]      br_target_q, br_target_d;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  // A flag-setting op in EX overrides the architectural flags in the same cycle.
  assign eff_flags = ex_set_flags ? ex_flags : flag_q;

  cond_eval u_cond_eval (
    .cond_i  (cond_e'(id_cond)),
    .flags_i (eff_flags),
    .taken_o (bcond_taken)
  );

  always_comb begin
    kind = KIND_NONE;
    if (id_is_b)          kind = KIND_B;
    else if (id_is_cbz)   kind = KIND_CBZ;
    else if (id_is_cbnz)  kind = KIND_CBNZ;
    else if (id_is_bcond) kind = KIND_BCOND;
  end

  always_comb begin
    taken_now = 1'b0;
    case (kind)
      KIND_B:     taken_now = 1'b1;
      KIND_CBZ:   taken_now = id_rt_zero;
      KIND_CBNZ:  taken_now = ~id_rt_zero;
      KIND_BCOND: taken_now = bcond_taken;
      default:    taken_now = 1'b0;
    endcase
  end

  assign flush  = (flush_cnt_q != '0);
  assign accept = id_valid & (kind != KIND_NONE) & ~flush;

  always_comb begin
    br_valid_d    = accept;
    br_taken_d    = br_taken_q;
    br_target_d   = br_target_q;
    flush_cnt_d   = flush_cnt_q;
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;

    if (flush) flush_cnt_d = flush_cnt_q - FCW'(1);

    if (accept) begin
      br_taken_d  = taken_now;
      br_target_d = branch_target(id_pc, id_imm);
      br_count_d  = br_count_q + CNT_W'(1);
      if (taken_now) begin
        taken_count_d = taken_count_q + CNT_W'(1);
        flush_cnt_d   = FCW'(FLUSH_CYCLES);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_valid_q    <= 1'b0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
      flush_cnt_q   <= '0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      br_valid_q    <= br_valid_d;
      br_taken_q    <= br_taken_d;
      br_target_q   <= br_target_d;
      flush_cnt_q   <= flush_cnt_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_valid    = br_valid_q;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve built with a 2-cycle flush and 4-bit counters.
module tb_branch_resolve;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       flag_q;
  logic             ex_set_flags;
  logic [3:0]       ex_flags;
  logic             id_valid;
  logic             id_is_b, id_is_cbz, id_is_cbnz, id_is_bcond;
  logic [3:0]       id_cond;
  logic             id_rt_zero;
  logic [63:0]      id_pc, id_imm;
  logic             br_valid, br_taken, flush;
  logic [63:0]      br_target;
  logic [CNT_W-1:0] br_count, taken_count;

  int total = 0;
  int bad   = 0;
  int exp_br = 0;
  int exp_tk = 0;

  always #5 clk = ~clk;

  branch_resolve #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flag_q(flag_q), .ex_set_flags(ex_set_flags),
    .ex_flags(ex_flags), .id_valid(id_valid), .id_is_b(id_is_b),
    .id_is_cbz(id_is_cbz), .id_is_cbnz(id_is_cbnz), .id_is_bcond(id_is_bcond),
    .id_cond(id_cond), .id_rt_zero(id_rt_zero), .id_pc(id_pc), .id_imm(id_imm),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .flush(flush), .br_count(br_count), .taken_count(taken_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_brcnt"}, 64'(br_count), 64'(exp_br & 15));
    check({tag, "_tkcnt"}, 64'(taken_count), 64'(exp_tk & 15));
  endtask

  // kinds = {b, cbz, cbnz, bcond}; drives one slot, samples 1 time unit after the edge.
  task automatic issue(input logic [3:0] kinds, input logic [3:0] cond, input logic rtz,
                       input logic [63:0] pc, input logic [63:0] imm);
    id_valid    = 1'b1;
    id_is_b     = kinds[3];
    id_is_cbz   = kinds[2];
    id_is_cbnz  = kinds[1];
    id_is_bcond = kinds[0];
    id_cond     = cond;
    id_rt_zero  = rtz;
    id_pc       = pc;
    id_imm      = imm;
    @(posedge clk); #1;
    id_valid    = 1'b0;
    id_is_b     = 1'b0;
    id_is_cbz   = 1'b0;
    id_is_cbnz  = 1'b0;
    id_is_bcond = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] cond_mask;
    int pulses;

    reset = 1'b1; flag_q = 4'h0; ex_set_flags = 1'b0; ex_flags = 4'h0;
    id_valid = 1'b0; id_is_b = 1'b0; id_is_cbz = 1'b0; id_is_cbnz = 1'b0;
    id_is_bcond = 1'b0; id_cond = 4'h0; id_rt_zero = 1'b0; id_pc = '0; id_imm = '0;
    idle(2);
    check("rst_valid", 64'(br_valid), 64'd0);
    check("rst_taken", 64'(br_taken), 64'd0);
    check("rst_target", br_target, 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check_counts("rst");
    reset = 1'b0;
    idle(1);

    // Forwarded Z=1 makes EQ taken even though flag_q is clear.
    flag_q = 4'b0000; ex_set_flags = 1'b1; ex_flags = 4'b0010;
    issue(4'b0001, 4'h0, 1'b0, 64'h1000, 64'd4);
    exp_br++; exp_tk++;
    check("fwd_valid", 64'(br_valid), 64'd1);
    check("fwd_taken", 64'(br_taken), 64'd1);
    check("fwd_flush", 64'(flush), 64'd1);
    check("fwd_target", br_target, 64'h1010);
    check_counts("fwd");
    idle(1);
    check("fwd_valid_pulse", 64'(br_valid), 64'd0);
    check("fwd_flush_hold", 64'(flush), 64'd1);
    idle(1);
    check("fwd_flush_drop", 64'(flush), 64'd0);

    // Architectural flags N=1,V=1: GE taken, LT not taken.
    ex_set_flags = 1'b0; ex_flags = 4'h0; flag_q = 4'b0101;
    issue(4'b0001, 4'hA, 1'b0, 64'h2000, 64'd1);
    exp_br++; exp_tk++;
    check("ge_taken", 64'(br_taken), 64'd1);
    idle(2);
    issue(4'b0001, 4'hB, 1'b0, 64'h2000, 64'd1);
    exp_br++;
    check("lt_taken", 64'(br_taken), 64'd0);
    check("lt_flush", 64'(flush), 64'd0);

    // In-flight op with Z=0 overrides a set Z in the register.
    flag_q = 4'b0010; ex_set_flags = 1'b1; ex_flags = 4'b0000;
    issue(4'b0001, 4'h0, 1'b0, 64'h40, 64'd0);
    exp_br++;
    check("fwd_over_taken", 64'(br_taken), 64'd0);
    ex_set_flags = 1'b0;

    // CBNZ on zero register, negative offset.
    issue(4'b0010, 4'h0, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE);
    exp_br++;
    check("cbnz_taken", 64'(br_taken), 64'd0);
    check("cbnz_target", br_target, 64'hF8);
    check("cbnz_flush", 64'(flush), 64'd0);
    check_counts("cbnz");

    // Priority: B beats CBZ(not-taken); CBZ(not-taken) beats CBNZ.
    issue(4'b1100, 4'h0, 1'b0, 64'h300, 64'd2);
    exp_br++; exp_tk++;
    check("prio_b_taken", 64'(br_taken), 64'd1);
    idle(2);
    issue(4'b0110, 4'h0, 1'b0, 64'h500, 64'd3);
    exp_br++;
    check("prio_cbz_taken", 64'(br_taken), 64'd0);
    check("prio_cbz_target", br_target, 64'h50C);

    // id_valid with no branch kind is not an accept; outputs hold.
    issue(4'b0000, 4'h0, 1'b0, 64'h900, 64'd9);
    check("nokind_valid", 64'(br_valid), 64'd0);
    check("nokind_target", br_target, 64'h50C);
    check_counts("nokind");

    // Taken B then B in both flush slots: both ignored.
    issue(4'b1000, 4'h0, 1'b0, 64'h1000, 64'd16);
    exp_br++; exp_tk++;
    pulses = int'(br_valid);
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      issue(4'b1000, 4'h0, 1'b0, 64'h7000, 64'd1);
      pulses += int'(br_valid);
    end
    check("flushslot_pulses", 64'(pulses), 64'd1);
    check("flushslot_target", br_target, 64'h1040);
    check("flushslot_flush", 64'(flush), 64'd0);
    check_counts("flushslot");

    // Condition-code sweep with N=1,Z=0,V=0,C=1.
    flag_q = 4'b1001;
    cond_mask = 16'hE996;
    for (int c = 0; c < 16; c++) begin
      issue(4'b0001, 4'(c), 1'b0, 64'h0, 64'd0);
      exp_br++;
      if (cond_mask[c]) exp_tk++;
      check($sformatf("cc%0d", c), 64'(br_taken), 64'(cond_mask[c]));
      idle(2);
    end
    check_counts("ccsweep");

    // Asynchronous reset in the middle of a flush.
    issue(4'b1000, 4'h0, 1'b0, 64'h1234, 64'd1);
    check("midrst_pre_flush", 64'(flush), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_flush", 64'(flush), 64'd0);
    check("midrst_valid", 64'(br_valid), 64'd0);
    check("midrst_taken", 64'(br_taken), 64'd0);
    check("midrst_target", br_target, 64'd0);
    exp_br = 0; exp_tk = 0;
    check_counts("midrst");
    @(negedge clk) reset = 1'b0;
    idle(1);

    // 16 taken branches wrap the 4-bit counters to zero.
    for (int i = 0; i < 16; i++) begin
      issue(4'b1000, 4'h0, 1'b0, 64'h0, 64'd1);
      exp_br++; exp_tk++;
      if (i == 14) check_counts("wrap15");
      idle(2);
    end
    check("wrap_br", 64'(br_count), 64'd0);
    check("wrap_tk", 64'(taken_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
